// File: rtl/aes128_round_engine_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers.
// Used by the round engine and its S-box.
package aes128_round_engine_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;
    localparam int AES_RK_W  = 1408;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes128_round_engine_sbox.sv
// AES forward S-box: GF(2^8) inverse as a^254, then the affine map.
// Purely combinational; the same cell serves key expansion's SubWord.
module aes128_round_engine_sbox
    import aes128_round_engine_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    logic [7:0] p2, p4, p8, p16, p32, p64, p128;
    logic [7:0] inv;

    assign p2   = gf_mul(a, a);
    assign p4   = gf_mul(p2, p2);
    assign p8   = gf_mul(p4, p4);
    assign p16  = gf_mul(p8, p8);
    assign p32  = gf_mul(p16, p16);
    assign p64  = gf_mul(p32, p32);
    assign p128 = gf_mul(p64, p64);

    // 254 = 2+4+8+16+32+64+128; zero maps to zero as required
    assign inv = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                        gf_mul(gf_mul(p32, p64), p128));

    assign y = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption engine, one round per clock, valid/ready I/O.
// Define AES_KEY_LATCH_EN to capture round_keys on accept.
module aes128_round_engine
    import aes128_round_engine_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] plaintext,
    input  logic [AES_RK_W-1:0]  round_keys,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] ciphertext,
    output logic                 busy
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes128_round_engine supports only NR=10");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t               state;
    logic [3:0]           rnd;
    logic [AES_BLK_W-1:0] state_reg;
    logic [AES_BLK_W-1:0] sb_out;
    logic [AES_BLK_W-1:0] sr_out;
    logic [AES_BLK_W-1:0] mc_out;
    logic [AES_BLK_W-1:0] rk_cur;
    logic [AES_BLK_W-1:0] rk0;
    logic [AES_BLK_W-1:0] nxt;
    logic [AES_RK_W-1:0]  rk_src;
    logic [AES_BLK_W-1:0] rk_arr [0:AES_NR];
    logic                 accept;

    // Byte k of a block sits at [127-8k -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3, t;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            t  = a0 ^ a1 ^ a2 ^ a3;
            o[127-32*c -: 8] = a0 ^ t ^ xtime(a0 ^ a1);
            o[119-32*c -: 8] = a1 ^ t ^ xtime(a1 ^ a2);
            o[111-32*c -: 8] = a2 ^ t ^ xtime(a2 ^ a3);
            o[103-32*c -: 8] = a3 ^ t ^ xtime(a3 ^ a0);
        end
        return o;
    endfunction

    assign accept = in_valid && in_ready;
    assign rk0    = round_keys[AES_RK_W-1 -: AES_BLK_W];

`ifdef AES_KEY_LATCH_EN
    logic [AES_RK_W-1:0] rk_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_reg <= '0;
        end else if (accept) begin
            rk_reg <= round_keys;
        end
    end

    assign rk_src = rk_reg;
`else
    assign rk_src = round_keys;
`endif

    for (genvar i = 0; i <= AES_NR; i++) begin : g_rk
        assign rk_arr[i] = rk_src[AES_RK_W-1-AES_BLK_W*i -: AES_BLK_W];
    end

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes128_round_engine_sbox u_sbox (
            .a (state_reg[127-8*i -: 8]),
            .y (sb_out[127-8*i -: 8])
        );
    end

    assign sr_out     = shift_rows(sb_out);
    assign mc_out     = mix_columns(sr_out);
    assign rk_cur     = rk_arr[rnd];
    assign nxt        = ((rnd == LAST_RND) ? sr_out : mc_out) ^ rk_cur;
    assign ciphertext = state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rnd       <= '0;
            state_reg <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= plaintext ^ rk0;
                        rnd       <= 4'd1;
                        state     <= ST_ROUND;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    state_reg <= nxt;
                    if (rnd == LAST_RND) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        rnd       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rnd       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_round_engine.sv
// Self-checking bench for aes128_round_engine: FIPS-197 vectors,
// handshake corners and random blocks against a byte-level AES model.
module tb_aes128_round_engine;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   plaintext;
    logic [1407:0]  round_keys;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   ciphertext;
    logic           busy;

    int checks;
    int errors;
    int k;
    logic [7:0] sb [256];
    vec_t vecs [3];

    aes128_round_engine dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .round_keys (round_keys),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built by brute-force inverse search plus the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1407:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]],
                       sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] key,
                                               input logic [127:0] pt);
        logic [1407:0] rks;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [127:0]  o;
        rks = expand(key);
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ rks[1407-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[4*c+w] = sb[s[4*((c+w)%4)+w]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    if (r < 10)
                        s[4*c+w] = gmul(8'h02, t[4*c+w])
                                 ^ gmul(8'h03, t[4*c+(w+1)%4])
                                 ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
                    else
                        s[4*c+w] = t[4*c+w];
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ rks[1407-128*r-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // One full transaction; hold keeps out_ready low with in_valid pulses
    task automatic do_block(input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] ct, input int hold,
                            input bit chg, input string nm);
        int n;
        @(negedge clk);
        round_keys = expand(key);
        plaintext  = pt;
        in_valid   = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " accept"}, 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        if (chg) round_keys = expand(128'h0);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 128'(n), 128'(11));
        chk({nm, " ct"}, ciphertext, ct);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            plaintext = ~pt;
            @(negedge clk);
            chk({nm, " hold out_valid"}, 128'(out_valid), 128'(1));
            chk({nm, " hold ct"}, ciphertext, ct);
            chk({nm, " hold in_ready"}, 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " drop out_valid"}, 128'(out_valid), 128'(0));
        chk({nm, " idle in_ready"}, 128'(in_ready), 128'(1));
        chk({nm, " idle busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        logic [127:0] rkey, rpt;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        plaintext  = '0;
        round_keys = '0;
        build_sbox();

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h0, 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        @(negedge clk);
        chk("reset in_ready", 128'(in_ready), 128'(1));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset ct", ciphertext, 128'h0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++)
            do_block(vecs[i].key, vecs[i].pt, vecs[i].ct,
                     (i == 2) ? 5 : 0, 1'b0, $sformatf("vec%0d", i));

        // reset during round 5, then a clean block
        @(negedge clk);
        round_keys = expand(vecs[0].key);
        plaintext  = vecs[0].pt;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset busy", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 128'(out_valid), 128'(0));
        chk("midrst ct", ciphertext, 128'h0);
        chk("midrst in_ready", 128'(in_ready), 128'(1));
        chk("midrst busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        do_block(vecs[1].key, vecs[1].pt, vecs[1].ct, 0, 1'b0, "after_rst");

        // back-to-back with in_valid and out_ready held high
        @(negedge clk);
        out_ready  = 1'b1;
        round_keys = expand(vecs[0].key);
        plaintext  = vecs[0].pt;
        in_valid   = 1'b1;
        chk("b2b first in_ready", 128'(in_ready), 128'(1));
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 40);
        chk("b2b first cycle", 128'(k), 128'(11));
        chk("b2b first ct", ciphertext, vecs[0].ct);
        round_keys = expand(vecs[1].key);
        plaintext  = vecs[1].pt;
        @(negedge clk);
        k++;
        chk("b2b second accept at 12", 128'(in_ready), 128'(1));
        @(negedge clk);
        k++;
        in_valid = 1'b0;
        chk("b2b second busy", 128'(busy), 128'(1));
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("b2b second cycle", 128'(k), 128'(23));
        chk("b2b second ct", ciphertext, vecs[1].ct);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b drain", 128'(out_valid), 128'(0));

`ifdef AES_KEY_LATCH_EN
        do_block(vecs[0].key, vecs[0].pt, vecs[0].ct, 0, 1'b1, "key_latch");
`endif

        for (int i = 0; i < 12; i++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            do_block(rkey, rpt, model_enc(rkey, rpt),
                     int'($urandom_range(0, 2)), 1'b0,
                     $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
